packet_registers: RTL and testbench
===================================

PACKET_REGISTERS -- requirements
Module: packet_registers

Interface
REQ-001 Parameter RESET_VAL, default 8'h00, reset value of every read/write register.
REQ-002 Parameter ERR_SAT, default 8'hFF, saturation value of the error counter.
REQ-003 Port ipClk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port ipReset  input  1  asynchronous, active-low reset.
REQ-005 Port ipRxStream  input  UART_PACKET  received packet from the UART packetiser; fields used: Valid, Destination, Source, Length, Data (8 bits each).
REQ-006 Port opTxStream  output  UART_PACKET  reply packet to the UART packetiser; fields driven: SoP, Valid, Destination, Source, Length, Data.
REQ-007 Port ipTxReady  input  1  packetiser accepts the current opTxStream byte.
REQ-008 Port ipStatus  input  32  read-only status; byte k maps to register address 12+k.
REQ-009 Port opControl  output  96  read/write registers 0..11; register n occupies bits [8n+7:8n].
REQ-010 Port opErrorCount  output  8  count of dropped or malformed requests.

Function
REQ-011 Register map: 16 byte addresses; 0..11 R/W, 12..15 read-only (ipStatus); address arithmetic modulo 16.
REQ-012 Request format: Destination = start address, Source = opcode (8'h00 read, 8'h01 write), Length = data byte count.
REQ-013 RX FSM states: IDLE, WRITE, READ_CNT, DISCARD; ipRxStream has no backpressure, so every Valid byte is consumed the cycle it appears.
REQ-014 IDLE: first Valid byte starts a packet; header fields are latched from that cycle; remaining count = Length-1.
REQ-015 Length 0 is treated as 1.
REQ-016 Write: byte i is written to address (Destination+i) mod 16 in the cycle it is Valid; writes to 12..15 are ignored without error.
REQ-017 Read: Length SHALL be 1; the data byte N (0 treated as 16, >16 clamped to 16) is the read count.
REQ-018 Read with Length != 1, or opcode not 0/1, SHALL increment opErrorCount and enter DISCARD until the remaining count reaches 0.
REQ-019 The FSM returns to IDLE in the cycle after the final byte of the packet.
REQ-020 Reply generation: after the final write byte, an ack is queued with Destination = start address, Source = 8'h01, Length = 1, Data = bytes written to addresses 0..11.
REQ-021 Reply generation: after the read count byte, a read reply is queued with Destination = start address, Source = 8'h00, Length = N, and N data bytes read from consecutive addresses mod 16.
REQ-022 Reply queue: one pending entry behind the active reply; a reply arriving with the entry full is dropped and opErrorCount increments.
REQ-023 TX FSM states: IDLE, SEND.
REQ-024 TX IDLE: on a queued reply, drive opTxStream.Valid=1 and SoP=1 with byte 0 in the cycle after the reply is queued.
REQ-025 TX SEND: a byte is accepted on a cycle with Valid && ipTxReady; the next byte is presented the following cycle; SoP is 1 only on byte 0.
REQ-026 Destination, Source and Length on opTxStream SHALL stay stable for the whole reply; Data and Valid SHALL hold until accepted.
REQ-027 Read data is sampled when each byte is loaded, so a write landing mid-reply is visible to later bytes.
REQ-028 Simultaneous write to address n and read of n in the same cycle returns the old value.
REQ-029 opErrorCount saturates at ERR_SAT; with two error sources in one cycle it increments by one.
REQ-030 After the last byte is accepted, Valid drops; the pending entry, if any, starts in the next cycle.

Reset
REQ-031 While ipReset=0, regardless of clock: registers 0..11 = RESET_VAL, opErrorCount = 0, both FSMs IDLE, queue empty, opTxStream all fields 0.
REQ-032 Reset mid-packet or mid-reply abandons it; after release the first Valid RX byte is treated as a new packet start.

Verification
REQ-033 Write Dest=2, Src=1, Len=3, data 0xA1,0xB2,0xC3 -> opControl bytes 2..4 = A1,B2,C3; ack Dest=2, Src=1, Len=1, Data=3.
REQ-034 Write Dest=14, Len=4, data 1,2,3,4 with wrap -> regs 0,1 = 3,4; regs 14,15 unchanged; ack Data=2.
REQ-035 ipStatus=0xDEADBEEF, read Dest=11, count 5 -> reply Len=5, data reg11,EF,BE,AD,DE; SoP on first byte only.
REQ-036 ipTxReady held low 10 cycles during a reply -> Data/Valid/header stable; no byte skipped or duplicated.
REQ-037 Three back-to-back reads while TX is stalled -> two replies sent in order; opErrorCount=1.
REQ-038 Opcode 0x07 with Len=2, then ipReset low mid-reply -> error counted and payload discarded; on reset, outputs return to reset values.

Source files
------------

// File: rtl/packet_registers.sv
// Byte-addressed register file reached over UART packets: writes are acked, reads
// stream back N bytes; one reply may wait behind the active one.
package packet_registers_pkg;
    typedef struct packed {
        logic       SoP;
        logic       Valid;
        logic [7:0] Destination;
        logic [7:0] Source;
        logic [7:0] Length;
        logic [7:0] Data;
    } UART_PACKET;
endpackage

module packet_registers
    import packet_registers_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter logic [7:0] ERR_SAT   = 8'hFF
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  UART_PACKET  ipRxStream,
    output UART_PACKET  opTxStream,
    input  logic        ipTxReady,
    input  logic [31:0] ipStatus,
    output logic [95:0] opControl,
    output logic [7:0]  opErrorCount
);
    typedef enum logic [1:0] {RX_IDLE, RX_WRITE, RX_READ_CNT, RX_DISCARD} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    typedef struct packed {
        logic       rd;
        logic [7:0] dest;
        logic [7:0] len;
        logic [7:0] ack;
    } reply_t;

    rx_state_t        rx_state, rx_next, rx_cur;
    tx_state_t        tx_state, tx_next;
    logic [7:0]       rem, left, eff_len, start, wr_cnt, cnt_cur, hdr_dest, err_cnt;
    logic [3:0]       wr_ptr, wr_addr, nxt_addr;
    logic             wr_en, rx_err, push, drop, load, adv, tx_acc;
    logic             pend_v, pend_take, pend_fill;
    reply_t           push_e, load_e, pend;
    logic [11:0][7:0] ctrl;
    logic [15:0][7:0] regmap;
    logic [4:0]       tx_idx;
    UART_PACKET       tx;
    logic             unused_sop;

    assign regmap       = {ipStatus, ctrl};
    assign opControl    = ctrl;
    assign opTxStream   = tx;
    assign opErrorCount = err_cnt;
    assign unused_sop   = ipRxStream.SoP;

    // In IDLE the packet type is decoded from the header riding on the first byte,
    // so that byte is processed in the same cycle as every later one.
    always_comb begin
        eff_len = (ipRxStream.Length == 8'd0) ? 8'd1 : ipRxStream.Length;
        rx_cur  = rx_state;
        if (rx_state == RX_IDLE) begin
            if (ipRxStream.Source == 8'h01)
                rx_cur = RX_WRITE;
            else if (ipRxStream.Source == 8'h00 && eff_len == 8'd1)
                rx_cur = RX_READ_CNT;
            else
                rx_cur = RX_DISCARD;
        end
        left     = (rx_state == RX_IDLE) ? eff_len - 8'd1 : rem - 8'd1;
        hdr_dest = (rx_state == RX_IDLE) ? ipRxStream.Destination : start;
        wr_addr  = (rx_state == RX_IDLE) ? ipRxStream.Destination[3:0] : wr_ptr;
        cnt_cur  = ((rx_state == RX_IDLE) ? 8'd0 : wr_cnt) + {7'd0, wr_addr < 4'd12};
        wr_en    = ipRxStream.Valid && rx_cur == RX_WRITE && wr_addr < 4'd12;
        rx_err   = ipRxStream.Valid && rx_state == RX_IDLE && rx_cur == RX_DISCARD;
        push     = ipRxStream.Valid && left == 8'd0 &&
                   (rx_cur == RX_WRITE || rx_cur == RX_READ_CNT);
        push_e.rd   = (rx_cur == RX_READ_CNT);
        push_e.dest = hdr_dest;
        push_e.len  = 8'd1;
        push_e.ack  = cnt_cur;
        if (rx_cur == RX_READ_CNT) begin
            push_e.len = (ipRxStream.Data == 8'd0 || ipRxStream.Data > 8'd16) ?
                         8'd16 : ipRxStream.Data;
            push_e.ack = 8'd0;
        end
        rx_next = rx_state;
        if (ipRxStream.Valid)
            rx_next = (left == 8'd0) ? RX_IDLE : rx_cur;
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            rem    <= 8'd0;
            start  <= 8'd0;
            wr_ptr <= 4'd0;
            wr_cnt <= 8'd0;
            ctrl   <= {12{RESET_VAL}};
        end else begin
            if (ipRxStream.Valid) begin
                rem    <= left;
                start  <= hdr_dest;
                wr_ptr <= wr_addr + 4'd1;
                wr_cnt <= cnt_cur;
            end
            for (int n = 0; n < 12; n++)
                if (wr_en && wr_addr == 4'(n)) ctrl[n] <= ipRxStream.Data;
        end
    end

    // A reply can bypass the pending slot only when TX is idle and nothing waits.
    always_comb begin
        tx_next   = tx_state;
        load      = 1'b0;
        load_e    = pend;
        pend_take = 1'b0;
        adv       = 1'b0;
        tx_acc    = tx.Valid && ipTxReady;
        nxt_addr  = tx.Destination[3:0] + tx_idx[3:0];
        case (tx_state)
            TX_IDLE: begin
                if (pend_v) begin
                    load      = 1'b1;
                    pend_take = 1'b1;
                    tx_next   = TX_SEND;
                end else if (push) begin
                    load    = 1'b1;
                    load_e  = push_e;
                    tx_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_acc) begin
                    if ({3'd0, tx_idx} == tx.Length) tx_next = TX_IDLE;
                    else                             adv     = 1'b1;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
        drop      = push && pend_v && !pend_take;
        pend_fill = push && !drop && !(tx_state == TX_IDLE && !pend_v);
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) tx_state <= TX_IDLE;
        else          tx_state <= tx_next;
    end

    // Read data comes from the live map at load time, so same-cycle writes are not seen.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            tx      <= '0;
            tx_idx  <= 5'd0;
            pend    <= '0;
            pend_v  <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            if (load) begin
                tx.SoP         <= 1'b1;
                tx.Valid       <= 1'b1;
                tx.Destination <= load_e.dest;
                tx.Source      <= load_e.rd ? 8'h00 : 8'h01;
                tx.Length      <= load_e.len;
                tx.Data        <= load_e.rd ? regmap[load_e.dest[3:0]] : load_e.ack;
                tx_idx         <= 5'd1;
            end else if (adv) begin
                tx.SoP  <= 1'b0;
                tx.Data <= regmap[nxt_addr];
                tx_idx  <= tx_idx + 5'd1;
            end else if (tx_acc) begin
                tx.SoP   <= 1'b0;
                tx.Valid <= 1'b0;
            end
            if (pend_fill) begin
                pend   <= push_e;
                pend_v <= 1'b1;
            end else if (pend_take) begin
                pend_v <= 1'b0;
            end
            if ((rx_err || drop) && err_cnt != ERR_SAT)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_packet_registers.sv
// Directed bench for packet_registers; expected reply bytes are queued at issue
// time and a negedge monitor compares every accepted TX byte.
`timescale 1ns/1ps
module tb_packet_registers;
    import packet_registers_pkg::*;

    typedef struct packed {
        logic       sop;
        logic [7:0] dest;
        logic [7:0] src;
        logic [7:0] len;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] status = 32'hDEADBEEF;
    UART_PACKET  rx, tx, held;
    logic [95:0] control;
    logic [7:0]  errc;
    exp_t        expq[$];
    exp_t        e;
    logic [7:0]  model[16];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          stalled = 0;

    always #5 clk = ~clk;

    packet_registers dut (
        .ipClk(clk), .ipReset(rst_n), .ipRxStream(rx), .opTxStream(tx),
        .ipTxReady(ready), .ipStatus(status), .opControl(control), .opErrorCount(errc)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 12; i++) model[i] = 8'h00;
        for (int k = 0; k < 4; k++) model[12+k] = status[8*k +: 8];
    endtask

    function automatic logic [95:0] model_ctrl();
        logic [95:0] v;
        for (int i = 0; i < 12; i++) v[8*i +: 8] = model[i];
        return v;
    endfunction

    task automatic rx_byte(input logic [7:0] d, input logic [7:0] s, input logic [7:0] l,
                           input logic [7:0] x);
        rx = '{SoP: 1'b0, Valid: 1'b1, Destination: d, Source: s, Length: l, Data: x};
        @(posedge clk); #1;
        rx = '0;
    endtask

    task automatic write_pkt(input logic [7:0] dest, input logic [7:0] len, input logic [31:0] dd);
        int nb = (len == 0) ? 1 : int'(len);
        logic [7:0] cnt = 0;
        logic [3:0] a;
        for (int i = 0; i < nb; i++) begin
            a = dest[3:0] + i[3:0];
            if (a < 12) begin
                model[a] = dd[8*i +: 8];
                cnt++;
            end
        end
        expq.push_back('{sop: 1'b1, dest: dest, src: 8'h01, len: 8'd1, data: cnt});
        for (int i = 0; i < nb; i++) rx_byte(dest, 8'h01, len, dd[8*i +: 8]);
    endtask

    task automatic read_pkt(input logic [7:0] dest, input logic [7:0] cnt, input bit expect_reply);
        logic [7:0] n = (cnt == 0 || cnt > 16) ? 8'd16 : cnt;
        logic [3:0] a;
        if (expect_reply)
            for (int i = 0; i < int'(n); i++) begin
                a = dest[3:0] + i[3:0];
                expq.push_back('{sop: (i == 0), dest: dest, src: 8'h00, len: n, data: model[a]});
            end
        rx_byte(dest, 8'h00, 8'd1, cnt);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expq.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (expq.size() != 0) begin
            n_checks++;
            $display("FAIL %s: %0d reply bytes still outstanding after %0d cycles", name, expq.size(), n);
            expq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: a byte transfers on a posedge where Valid && ready, sampled on the prior negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled) check("stall_hold", tx, held);
            if (tx.Valid && ready) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_reply: got dest %0h src %0h len %0h data %0h, expected none",
                             tx.Destination, tx.Source, tx.Length, tx.Data);
                end else begin
                    e = expq.pop_front();
                    check("reply_byte", {tx.SoP, tx.Destination, tx.Source, tx.Length, tx.Data}, e);
                end
            end
            stalled = tx.Valid && !ready;
            held    = tx;
        end
    end

    initial begin
        rx = '0;
        reset_model();
        #12;
        check("reset_ctrl", control, {12{8'h00}});
        check("reset_err", errc, 8'h00);
        check("reset_tx", tx, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        write_pkt(8'd2, 8'd3, 32'h00C3B2A1);
        drain("req033");
        check("req033_regs", control[39:16], 24'hC3B2A1);

        write_pkt(8'd14, 8'd4, 32'h04030201);
        drain("req034");
        check("req034_regs01", control[15:0], 16'h0403);
        check("req034_keep", control[39:16], 24'hC3B2A1);

        write_pkt(8'd11, 8'd1, 32'h5A);
        write_pkt(8'd7, 8'd0, 32'h77);
        drain("len0_write");
        check("len0_reg7", control[63:56], 8'h77);
        check("reg11", control[95:88], 8'h5A);

        read_pkt(8'd11, 8'd5, 1);
        drain("req035");

        read_pkt(8'd2, 8'd3, 1);
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        ready = 1'b1;
        drain("req036");

        ready = 1'b0;
        read_pkt(8'd0, 8'd2, 1);
        read_pkt(8'd12, 8'd1, 1);
        read_pkt(8'd5, 8'd1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("req037_err", errc, 8'd1);
        ready = 1'b1;
        drain("req037");

        read_pkt(8'd0, 8'd0, 1);
        drain("read_cnt0");
        read_pkt(8'd12, 8'd20, 1);
        drain("read_cnt20");
        check("ctrl_model", control, model_ctrl());

        rx_byte(8'd3, 8'h07, 8'd2, 8'h55);
        rx_byte(8'd3, 8'h07, 8'd2, 8'h66);
        repeat (4) @(posedge clk);
        #1;
        check("req038_err", errc, 8'd2);
        check("req038_ctrl", control, model_ctrl());
        ready = 1'b0;
        read_pkt(8'd0, 8'd16, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("req038_rst_tx", tx, '0);
        check("req038_rst_ctrl", control, {12{8'h00}});
        check("req038_rst_err", errc, 8'h00);
        reset_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;

        rx_byte(8'd9, 8'h01, 8'd3, 8'h11);
        rst_n = 1'b0;
        #2;
        check("midpkt_rst_reg9", control[79:72], 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        write_pkt(8'd9, 8'd1, 32'h99);
        drain("req032");
        check("req032_ctrl", control, model_ctrl());

        for (int i = 0; i < 300; i++) rx_byte(8'd0, 8'h07, 8'd1, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("err_saturate", errc, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
